// File: rtl/signed_muldiv_seq.sv
`default_nettype none
// ============================================================================
// signed_muldiv_seq : iterative signed multiply / divide, WIDTH iterations on
// one shared adder. Optional MULDIV_OVF_FLAG_EN adds a quotient overflow flag.
// Revision: 1.0
// ============================================================================
module signed_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               muordi,
  input  logic [WIDTH-1:0]   opera1,
  input  logic [2*WIDTH-1:0] opera2,
  output logic [2*WIDTH-1:0] result,
  output logic               valid,
  output logic               busy,
  output logic               divzero
`ifdef MULDIV_OVF_FLAG_EN
  ,
  output logic               ovf
`endif
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_load = 2'd1;
  localparam logic [1:0] c_st_iter = 2'd2;
  localparam logic [1:0] c_st_fix  = 2'd3;

  logic [1:0]         r_state;
  logic [c_cnt_w-1:0] r_count;
  logic               r_mode;
  logic [WIDTH-1:0]   r_op1;
  logic [2*WIDTH-1:0] r_op2;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_dz;
  logic [WIDTH:0]     r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH:0]     r_b;
  logic [2*WIDTH-1:0] r_result;
  logic               r_valid;
  logic               r_divzero;
`ifdef MULDIV_OVF_FLAG_EN
  logic               r_ovf_big;
  logic               r_ovf;
`endif

  logic [WIDTH-1:0]   w_op1_mag;
  logic [WIDTH-1:0]   w_mc_mag;
  logic [2*WIDTH-1:0] w_n_mag;
  logic [WIDTH-1:0]   w_hi_rem;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_add_a;
  logic [WIDTH:0]     w_add_b;
  logic [WIDTH+1:0]   w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_op1_mag = r_op1[WIDTH-1] ? (~r_op1 + WIDTH'(1)) : r_op1;
  assign w_mc_mag  = r_op2[WIDTH-1] ? (~r_op2[WIDTH-1:0] + WIDTH'(1)) : r_op2[WIDTH-1:0];
  assign w_n_mag   = r_op2[2*WIDTH-1] ? (~r_op2 + (2*WIDTH)'(1)) : r_op2;

  // Pre-reducing the upper dividend half keeps the remainder exact and the
  // low quotient bits correct even when the full quotient exceeds WIDTH bits.
  assign w_hi_rem  = (w_op1_mag == '0) ? '0 : (w_n_mag[2*WIDTH-1:WIDTH] % w_op1_mag);

  // Shared adder: add (multiply) or trial-subtract (divide); MSB is the borrow.
  assign w_shift = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
  assign w_add_a = r_mode ? w_shift : r_hi;
  assign w_add_b = (r_mode | r_lo[0]) ? r_b : '0;
  assign w_sum   = {1'b0, w_add_a} + ({1'b0, w_add_b} ^ {(WIDTH+2){r_mode}})
                 + (WIDTH+2)'(r_mode);

  assign w_prod     = {r_hi[WIDTH-1:0], r_lo};
  assign w_prod_fix = r_neg_res ? (~w_prod + (2*WIDTH)'(1)) : w_prod;
  assign w_quot     = r_neg_res ? (~r_lo + WIDTH'(1)) : r_lo;
  assign w_rem      = r_neg_rem ? (~r_hi[WIDTH-1:0] + WIDTH'(1)) : r_hi[WIDTH-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= c_st_idle;
      r_count   <= '0;
      r_mode    <= 1'b0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dz      <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_divzero <= 1'b0;
`ifdef MULDIV_OVF_FLAG_EN
      r_ovf_big <= 1'b0;
      r_ovf     <= 1'b0;
`endif
    end else begin
      r_valid   <= 1'b0;
      r_divzero <= 1'b0;
`ifdef MULDIV_OVF_FLAG_EN
      r_ovf     <= 1'b0;
`endif
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_mode  <= muordi;
            r_op1   <= opera1;
            r_op2   <= opera2;
            r_state <= c_st_load;
          end
        end
        c_st_load: begin
          r_neg_res <= r_op1[WIDTH-1] ^ (r_mode ? r_op2[2*WIDTH-1] : r_op2[WIDTH-1]);
          r_neg_rem <= r_op2[2*WIDTH-1];
          r_dz      <= r_mode & (r_op1 == '0);
          r_b       <= {1'b0, (r_mode ? w_op1_mag : w_mc_mag)};
          r_lo      <= r_mode ? w_n_mag[WIDTH-1:0] : w_op1_mag;
          r_hi      <= r_mode ? {1'b0, w_hi_rem} : '0;
`ifdef MULDIV_OVF_FLAG_EN
          r_ovf_big <= (w_n_mag[2*WIDTH-1:WIDTH] >= w_op1_mag);
`endif
          r_count   <= c_cnt_w'(WIDTH);
          r_state   <= c_st_iter;
        end
        c_st_iter: begin
          if (r_mode) begin
            r_hi <= w_sum[WIDTH+1] ? w_shift : w_sum[WIDTH:0];
            r_lo <= {r_lo[WIDTH-2:0], ~w_sum[WIDTH+1]};
          end else begin
            r_hi <= {1'b0, w_sum[WIDTH:1]};
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
          end
          r_count <= r_count - c_cnt_w'(1);
          if (r_count == c_cnt_w'(1))
            r_state <= c_st_fix;
        end
        c_st_fix: begin
          if (!r_mode)
            r_result <= w_prod_fix;
          else if (r_dz)
            r_result <= {r_op2[WIDTH-1:0], {WIDTH{1'b1}}};
          else
            r_result <= {w_rem, w_quot};
          r_valid   <= 1'b1;
          r_divzero <= r_mode & r_dz;
`ifdef MULDIV_OVF_FLAG_EN
          // Quotient magnitude of exactly 2^(W-1) is legal only when negative.
          r_ovf <= r_mode & ~r_dz & (r_ovf_big |
                   (r_lo[WIDTH-1] & (~r_neg_res | (r_lo[WIDTH-2:0] != '0))));
`endif
          r_state   <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign result  = r_result;
  assign valid   = r_valid;
  assign divzero = r_divzero;
  assign busy    = (r_state != c_st_idle) | r_valid;
`ifdef MULDIV_OVF_FLAG_EN
  assign ovf     = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_signed_muldiv_seq.sv
`default_nettype none
// Scoreboard bench for signed_muldiv_seq: stimulus pushes expected results,
// a negedge monitor pops and compares whenever valid is seen.
module tb_signed_muldiv_seq;
  localparam int W = 32;

  logic           clock;
  logic           reset;
  logic           start;
  logic           muordi;
  logic [W-1:0]   opera1;
  logic [2*W-1:0] opera2;
  logic [2*W-1:0] result;
  logic           valid;
  logic           busy;
  logic           divzero;
`ifdef MULDIV_OVF_FLAG_EN
  logic           ovf;
`endif

  signed_muldiv_seq #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .muordi  (muordi),
    .opera1  (opera1),
    .opera2  (opera2),
    .result  (result),
    .valid   (valid),
    .busy    (busy),
    .divzero (divzero)
`ifdef MULDIV_OVF_FLAG_EN
    ,
    .ovf     (ovf)
`endif
  );

  typedef struct {
    logic [2*W-1:0] res;
    logic           dz;
    logic           ov;
    int             acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Reference: plain signed arithmetic on wide integers.
  function automatic exp_t model(input logic m, input logic [W-1:0] a, input logic [2*W-1:0] b);
    exp_t e;
    logic signed [127:0] sa, sb, p, q, r, qmax, qmin;
    e.res = '0; e.dz = 1'b0; e.ov = 1'b0; e.acc = 0;
    sa = {{(128-W){a[W-1]}}, a};
    qmax = (128'sd1 <<< (W-1)) - 128'sd1;
    qmin = -(128'sd1 <<< (W-1));
    if (!m) begin
      sb = {{(128-W){b[W-1]}}, b[W-1:0]};
      p = sa * sb;
      e.res = p[2*W-1:0];
    end else if (a == '0) begin
      e.res = {b[W-1:0], {W{1'b1}}};
      e.dz  = 1'b1;
    end else begin
      sb = {{(128-2*W){b[2*W-1]}}, b};
      q = sb / sa;
      r = sb % sa;
      e.res = {r[W-1:0], q[W-1:0]};
      e.ov  = (q > qmax) || (q < qmin);
    end
    return e;
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      chk("busy", busy, exp_q.size() != 0);
      if (valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", valid, 0);
        end else begin
          m_e = exp_q.pop_front();
          chk("result", result, m_e.res);
          chk("divzero", divzero, m_e.dz);
          chk("latency", cyc - m_e.acc, W + 2);
`ifdef MULDIV_OVF_FLAG_EN
          chk("ovf", ovf, m_e.ov);
`endif
        end
      end
    end
  end

  task automatic push_exp(input logic m, input logic [W-1:0] a, input logic [2*W-1:0] b);
    exp_t e;
    e = model(m, a, b);
    e.acc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic scramble();
    muordi = 1'($urandom);
    opera1 = W'($urandom);
    opera2 = {$urandom, $urandom};
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("idle_wait", exp_q.size() != 0, 0);
    exp_q.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input logic m, input logic [W-1:0] a, input logic [2*W-1:0] b);
    wait_idle();
    start = 1'b1; muordi = m; opera1 = a; opera2 = b;
    @(posedge clock); #1;
    start = 1'b0;
    push_exp(m, a, b);
    scramble();
  endtask

  function automatic logic [W-1:0] pick_op1();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return {1'b1, {(W-1){1'b0}}};
      4: return {1'b0, {(W-1){1'b1}}};
      5: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [2*W-1:0] pick_op2();
    logic [W-1:0] t;
    t = W'($urandom);
    case ($urandom_range(0, 5))
      0: return {{W{t[W-1]}}, t};
      1: return {1'b1, {(2*W-1){1'b0}}};
      2: return (2*W)'($urandom_range(0, 255));
      3: return {{W{1'b1}}, t};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic          m;
    logic [W-1:0]  a;
    int            n;
    reset = 1'b1; start = 1'b0; muordi = 1'b0; opera1 = '0; opera2 = '0;
    #3;
    chk("reset_result", result, 0);
    chk("reset_valid", valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_divzero", divzero, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    issue(1'b0, W'(-7), (2*W)'(6));
    issue(1'b0, {1'b1, {(W-1){1'b0}}}, {{W{1'b0}}, 1'b1, {(W-1){1'b0}}});
    issue(1'b1, W'(7), (2*W)'(-100));
    issue(1'b1, '0, 64'h00000000_12345678);
`ifdef MULDIV_OVF_FLAG_EN
    issue(1'b1, W'(1), 64'h00000100_00000000);
    issue(1'b1, W'(1), 64'h00000000_7FFFFFFF);
`endif

    // Back-to-back: request raised while valid is high, then an ignored pulse.
    issue(1'b0, pick_op1(), pick_op2());
    n = 0;
    while (!valid && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("b2b_valid_seen", valid, 1);
    start = 1'b1; muordi = 1'b1; opera1 = W'(-9); opera2 = (2*W)'(1000);
    @(posedge clock); #1;
    start = 1'b0;
    push_exp(1'b1, W'(-9), (2*W)'(1000));
    repeat (5) @(posedge clock);
    #1;
    start = 1'b1; scramble();
    @(posedge clock); #1;
    start = 1'b0;

    // Reset during an operation, then a fresh 3*5 with an ignored start.
    issue(1'b0, W'(123456), (2*W)'(-789));
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("abort_result", result, 0);
    chk("abort_valid", valid, 0);
    chk("abort_busy", busy, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    issue(1'b0, W'(3), (2*W)'(5));
    repeat (7) @(posedge clock);
    #1;
    start = 1'b1; scramble();
    @(posedge clock); #1;
    start = 1'b0;

    for (int i = 0; i < 150; i++) begin
      m = 1'($urandom);
      a = pick_op1();
      issue(m, a, pick_op2());
    end

    wait_idle();
    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/signed_muldiv_seq.md
Name: signed_muldiv_seq

Overview:
- Parametrised, iterative signed multiply/divide unit; successor of the 32-bit control/add32 datapath.
- Generalised to any operand width `WIDTH`, with:
  - fixed, documented latency;
  - a busy/valid handshake;
  - a divide-by-zero flag.
- One shared `WIDTH`-bit adder/subtractor is reused every iteration.
- Sits between the operand registers and the result writeback of the arithmetic core.

Parameters:
- `WIDTH`, 32, operand width `W`. Legal range 4..64. Result is `2W` bits.

Ports:
- `clock`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request. Sampled only in IDLE.
- `muordi`, input, 1: mode. 0 = multiply, 1 = divide. Latched at accept.
- `opera1`, input, `W`: multiplier (multiply) or divisor (divide). Two's complement. Latched at accept.
- `opera2`, input, `2W`: multiplicand in `[W-1:0]` (multiply, upper half ignored) or dividend, full `2W` (divide). Latched at accept.
- `result`, output, `2W`:
  - multiply: signed product;
  - divide: `{remainder, quotient}`.
- `valid`, output, 1: one-cycle pulse when `result` is updated.
- `busy`, output, 1: high from the cycle after accept until `valid`, inclusive.
- `divzero`, output, 1: set with `valid` when a divide had `opera1 == 0`.

Behaviour:
- Reset: asynchronous, clears everything.
  - `result = 0`, `valid = 0`, `busy = 0`, `divzero = 0`, all internal registers 0, state = IDLE.
  - Reset mid-operation aborts immediately; no `valid` follows.
- Accept: in IDLE, `start = 1` at a rising edge latches `muordi`, `opera1` and `opera2`, and moves to LOAD.
  - `start` while busy is ignored; the operation in flight is unaffected.
- States:
  - IDLE -> LOAD on accept. `valid` and `divzero` return to 0 one cycle after they pulse.
  - LOAD (1 cycle): compute sign flags and magnitudes.
    - `neg_res` = sign(op1) XOR sign(op2).
    - Divide only: `neg_rem` = sign of the dividend.
    - Divide by zero detected here.
    - Go to ITER with `count = W`.
  - ITER (`W` cycles): one adder operation per cycle; `count` decrements; leave when `count` reaches 1.
    - Multiply: shift-add on magnitudes. If the accumulator LSB is 1, add the multiplicand to the upper half, then shift right 1 with carry-in.
    - Divide: restoring division on magnitudes. Shift the partial remainder left 1 and trial-subtract the divisor magnitude.
      - Non-negative: keep the difference and set the quotient bit to 1.
      - Otherwise: restore and set the quotient bit to 0.
  - FIX (1 cycle): apply two's-complement negation where needed, write `result`, assert `valid`, return to IDLE.
    - Multiply: negate the `2W`-bit product when `neg_res` is set.
    - Divide: negate the quotient when `neg_res` is set; negate the remainder when `neg_rem` is set.
- Latency:
  - `valid` rises on the (`W`+2)th rising edge after the accepting edge; 34 for `W` = 32.
  - Identical for every operand value, mode and divide-by-zero.
  - Back-to-back: `start` may be high in the cycle `valid` is high. It is accepted only if the state is IDLE at that edge (i.e. the next edge); throughput is one op per `W`+3 cycles.
- Arithmetic rules:
  - Multiply: `result` equals the exact signed product, sign-extended to `2W` bits. `-2^(W-1) * -2^(W-1)` = `2^(2W-2)`, which is representable.
  - Divide: truncates toward zero. Remainder takes the dividend's sign, and `|rem| < |divisor|`.
  - Divide quotient: if the true quotient exceeds `W` bits, `result[W-1:0]` holds its low `W` bits; the remainder is still exact.
  - Most-negative divisor: magnitude is handled as an unsigned `W+1`-bit value internally. No corruption.
- Divide by zero:
  - Iterations still run, for fixed latency.
  - FIX forces quotient = all ones and remainder = `opera2[W-1:0]` as latched, and sets `divzero = 1` with `valid`.
- `result` holds its value until the next FIX or reset.

Optional Feature:
- Macro: `MULDIV_OVF_FLAG_EN`.
- When defined:
  - Adds output port `ovf` (1 bit), reset 0, pulsing with `valid`.
  - `ovf` = 1 for a divide whose true signed quotient is outside `[-2^(W-1), 2^(W-1)-1]` (divide-by-zero excluded).
  - Detection is in LOAD: compare the upper half of the dividend magnitude against the divisor magnitude, plus a one-bit sign check in FIX.
  - `result` is unchanged (truncated).
- When undefined: no `ovf` port and no overflow logic; truncation is silent.

Test Plan:
- `W`=32, multiply, `opera1` = -7, `opera2[31:0]` = 6, pulse `start` -> after 34 edges `valid` = 1 for 1 cycle, `result` = 0xFFFFFFFF_FFFFFFD6, `busy` low the next cycle.
- `W`=32, multiply, `opera1` = `opera2[31:0]` = 0x80000000 -> `result` = 0x40000000_00000000.
- `W`=32, divide, `opera2` = -100 (0xFFFFFFFF_FFFFFF9C), `opera1` = 7 -> `result` = 0xFFFFFFFE_FFFFFFF2 (rem -2, quot -14), `divzero` = 0.
- `W`=32, divide, `opera1` = 0, `opera2` = 0x00000000_12345678 -> latency 34, `result` = 0x12345678_FFFFFFFF, `divzero` = 1.
- Start a multiply, assert `reset` for 1 cycle at iteration 10 -> `result`/`valid`/`busy` go 0 asynchronously and no `valid` appears. Then `start` with 3*5 -> `result` = 15 after 34 edges. A second `start` pulse during that op is ignored.
- With `MULDIV_OVF_FLAG_EN`, `W`=32: divide 0x00000100_00000000 by 1 -> `ovf` = 1 with `valid`, `result[31:0]` = 0. Repeat with 0x7FFFFFFF / 1 -> `ovf` = 0. Repeat with `W`=8: 0xFF80 / 0xFF (-128 / -1) -> `ovf` = 1.
